// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial port link: frame state encoding,
// address width helper and the parity function used on both link ends.
package serial_port_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4,
        DONE  = 3'd5
    } tx_state_e;

    // Address field width for a given port count; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Even parity over a zero-extended word (payloads up to 32 bits).
    function automatic logic even_par(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/serial_port_tx_if.sv
// Word-offer handshake into the serial transmitter: one (port, data)
// word moves on every clock where in_valid and in_ready are both high.
interface serial_port_tx_if
    import serial_port_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int N_PORTS = 4
) ();
    localparam int ADDR_W = addr_w(N_PORTS);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_port;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_port, output in_data, input in_ready);
    modport slave  (input in_valid, input in_port, input in_data, output in_ready);
endinterface

// File: rtl/serial_port_piso.sv
// Loadable parallel-in serial-out shift register with a saturating count
// of bits shifted out since the last load. bit_o always shows the bit that
// the next shift will consume.
module serial_port_piso #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [W-1:0]           load_val_i,
    input  logic                   shift_i,
    output logic                   bit_o,
    output logic [$clog2(W+1)-1:0] cnt_o
);
    localparam int CW = $clog2(W+1);

    logic [W-1:0]  sr_q;
    logic [CW-1:0] cnt_q;

    // Shift register holds payload only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i)
            sr_q <= load_val_i;
        else if (shift_i)
            sr_q <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end

    // Bit counter restarts on load and sticks at W instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= '0;
        else if (shift_i && (cnt_q != CW'(W)))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bit_o = MSB_FIRST ? sr_q[W-1] : sr_q[0];
    assign cnt_o = cnt_q;
endmodule

// File: rtl/serial_port_tx.sv
// Serial port transmitter: start bit, destination port (MSB first), data
// (LSB first), optional even parity, then a one-cycle done pulse. lb/pb/
// bit_vld let a same-clock port demultiplexer consume the data bits directly.
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state register without an extra cycle of latency.
module serial_port_tx
    import serial_port_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int N_PORTS   = 4,
    parameter bit PARITY_EN = 1'b0,
    parameter bit IDLE_LVL  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_port_tx_if.slave           tx_if,
    output logic                      serout,
    output logic [$clog2(DATA_W)-1:0] lb,
    output logic [N_PORTS-1:0]        pb,
    output logic                      bit_vld,
    output logic                      done
);
    localparam int ADDR_W = addr_w(N_PORTS);
    localparam int LB_W   = $clog2(DATA_W);
    localparam int ACW    = $clog2(ADDR_W + 1);
    localparam int DCW    = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_ADDR  = ADDR;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_PAR   = PAR;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               serout_q, serout_d;
    logic [LB_W-1:0]    lb_q, lb_d;
    logic [N_PORTS-1:0] pb_q, pb_d;
    logic               bit_vld_q, bit_vld_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  port_q;
    logic               par_q;

    logic               accept;
    logic               addr_bit, data_bit;
    logic [ACW-1:0]     addr_cnt;
    logic [DCW-1:0]     data_cnt;

    assign accept = tx_if.in_valid && in_ready_q;

    serial_port_piso #(.W(ADDR_W), .MSB_FIRST(1'b1)) u_addr_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (tx_if.in_port),
        .shift_i    (state_d == S_ADDR),
        .bit_o      (addr_bit),
        .cnt_o      (addr_cnt)
    );

    serial_port_piso #(.W(DATA_W), .MSB_FIRST(1'b0)) u_data_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (tx_if.in_data),
        .shift_i    (state_d == S_DATA),
        .bit_o      (data_bit),
        .cnt_o      (data_cnt)
    );

    // Frame sequencing; each shifting phase ends once its field is fully out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_ADDR;
            S_ADDR:  if (addr_cnt == ACW'(ADDR_W)) state_d = S_DATA;
            S_DATA:  if (data_cnt == DCW'(DATA_W)) state_d = PARITY_EN ? S_PAR : S_DONE;
            S_PAR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered at the next edge.
    always_comb begin
        serout_d   = IDLE_LVL;
        lb_d       = '0;
        pb_d       = '0;
        bit_vld_d  = 1'b0;
        done_d     = 1'b0;
        in_ready_d = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d = 1'b1;
            S_START: serout_d = ~IDLE_LVL;
            S_ADDR:  serout_d = addr_bit;
            S_DATA: begin
                serout_d  = data_bit;
                lb_d      = data_cnt[LB_W-1:0];
                pb_d      = {{(N_PORTS-1){1'b0}}, 1'b1} << port_q;
                bit_vld_d = 1'b1;
            end
            S_PAR:   serout_d = par_q;
            S_DONE:  done_d = 1'b1;
            default: serout_d = IDLE_LVL;
        endcase
    end

    // Control state and registered outputs; reset abandons any frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            serout_q   <= IDLE_LVL;
            lb_q       <= '0;
            pb_q       <= '0;
            bit_vld_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            serout_q   <= serout_d;
            lb_q       <= lb_d;
            pb_q       <= pb_d;
            bit_vld_q  <= bit_vld_d;
            done_q     <= done_d;
        end
    end

    // Captured destination and parity for the word in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            port_q <= tx_if.in_port;
            par_q  <= even_par(32'(tx_if.in_data));
        end
    end

    assign tx_if.in_ready = in_ready_q;
    assign serout         = serout_q;
    assign lb             = lb_q;
    assign pb             = pb_q;
    assign bit_vld        = bit_vld_q;
    assign done           = done_q;
endmodule
